// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three buses around the memory arbiter: the instruction-fetch
// requester, the load/store requester and the single downstream memory port.
//
// Handshake rule, identical on every channel: a request transfers in the
// cycle where valid and ready are both 1. A requester keeps its fields stable
// while valid is high and ready is low. Responses (*_resp_valid) are
// one-cycle pulses with no backpressure: the receiver must take them.
//
// Modports:
//   slave  - the arbiter's view (takes requests, drives the memory port)
//   master - the environment's view (requesters plus the memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    // instruction fetch (read-only)
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_resp_err;

    // load/store
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_resp_err;

    // downstream memory
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp_err;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between the IFU and the LSU. One transaction is in
// flight at a time: IDLE -> REQ -> WAIT -> RESP -> IDLE. Simultaneous
// requests are resolved round-robin. If the memory does not accept and answer
// within TIMEOUT cycles, an error response (err=1, rdata=0) is returned.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   bus        - mem_arbiter_if.slave: IFU, LSU and memory channels
//   busy       - 1 whenever the FSM is not in IDLE
//   state_dbg  - current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    mem_arbiter_if.slave        bus,
    output logic                busy,
    output logic [1:0]          state_dbg
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              last_grant_q;
    logic              owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic grant_ifu, grant_lsu;
    logic ifu_hs, lsu_hs;
    logic timeout_hit;

    // Grant only in IDLE; a lone requester always wins, a tie goes to the
    // side that did not win last time.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_q == S_IDLE) begin
            if (bus.ifu_req_valid && bus.lsu_req_valid) begin
                grant_ifu = (last_grant_q == OWN_LSU);
                grant_lsu = (last_grant_q == OWN_IFU);
            end else begin
                grant_ifu = bus.ifu_req_valid;
                grant_lsu = bus.lsu_req_valid;
            end
        end
    end

    assign ifu_hs = bus.ifu_req_valid && grant_ifu;
    assign lsu_hs = bus.lsu_req_valid && grant_lsu;

    // The counter saturates at TIMEOUT-1, so the compare stays true until the
    // FSM leaves REQ/WAIT even if the exit event won on the boundary cycle.
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ifu_hs || lsu_hs) state_d = S_REQ;
            S_REQ: begin
                if (bus.mem_req_ready)  state_d = S_WAIT;
                else if (timeout_hit)   state_d = S_RESP;
            end
            S_WAIT: begin
                if (bus.mem_resp_valid) state_d = S_RESP;
                else if (timeout_hit)   state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= OWN_LSU;
            owner_q      <= OWN_IFU;
            cnt_q        <= '0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (ifu_hs || lsu_hs) begin
                        addr_q       <= lsu_hs ? bus.lsu_addr  : bus.ifu_addr;
                        wen_q        <= lsu_hs && bus.lsu_wen;
                        wdata_q      <= lsu_hs ? bus.lsu_wdata : '0;
                        wmask_q      <= lsu_hs ? bus.lsu_wmask : '0;
                        owner_q      <= lsu_hs ? OWN_LSU : OWN_IFU;
                        last_grant_q <= lsu_hs ? OWN_LSU : OWN_IFU;
                        cnt_q        <= '0;
                    end
                end
                S_REQ: begin
                    if (!timeout_hit) cnt_q <= cnt_q + CNT_W'(1);
                    if (!bus.mem_req_ready && timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!timeout_hit) cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.mem_resp_valid) begin
                        rdata_q <= bus.mem_rdata;
                        err_q   <= bus.mem_resp_err;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ifu_req_ready  = grant_ifu;
    assign bus.lsu_req_ready  = grant_lsu;

    assign bus.mem_req_valid  = (state_q == S_REQ);
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;

    assign bus.ifu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_IFU);
    assign bus.ifu_resp_err   = bus.ifu_resp_valid && err_q;
    assign bus.ifu_rdata      = rdata_q;

    assign bus.lsu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_LSU);
    assign bus.lsu_resp_err   = bus.lsu_resp_valid && err_q;
    assign bus.lsu_rdata      = rdata_q;

    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int TO = 8;
    localparam int EW = 42;   // {owner_lsu, err, rdata[31:0], latency[7:0]}
    localparam logic [1:0] DBG_IDLE = 2'd0;
    localparam logic [1:0] DBG_WAIT = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [1:0] state_dbg;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic last_lsu;              // model: side that won the previous grant
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic observe(input logic who, input logic [31:0] rd, input logic err, input int c);
        logic [EW-1:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL resp_unexpected: got pulse owner_lsu=%0d cycle %0d want none", who, c);
            return;
        end
        e = exp_q.pop_front();
        check("resp_owner", 32'(who), 32'(e[41]));
        check("resp_err",   32'(err), 32'(e[40]));
        check("resp_rdata", rd, e[39:8]);
        check("resp_lat",   32'(c), 32'(e[7:0]));
    endtask

    // Reference model: who wins and what comes back, from the arbitration
    // and timeout rules. Stalls are limited to <= TO-2 or "never ready".
    function automatic void predict(input logic ifu_v, input logic lsu_v, input int stall, input int delay,
                                    input logic [31:0] mrd, input logic merr,
                                    output logic own_lsu, output int lat, output logic err,
                                    output logic [31:0] rd);
        if (ifu_v && lsu_v) own_lsu = !last_lsu;
        else                own_lsu = lsu_v;
        if (stall < TO && stall + delay + 2 <= TO) begin
            lat = stall + delay + 3; err = merr; rd = mrd;
        end else begin
            lat = TO + 1; err = 1'b1; rd = 32'h0;
        end
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1 with the arbiter idle. Cycle 0 is the handshake.
    task automatic do_txn(input logic ifu_v, input logic lsu_v, input logic [31:0] ia, input logic [31:0] la,
                          input logic wen, input logic [31:0] wd, input logic [3:0] wm,
                          input int stall, input int delay, input logic [31:0] mrd, input logic merr,
                          input logic stray, input logic exp_lsu, input int exp_lat,
                          input logic exp_err, input logic [31:0] exp_rd);
        logic acc;
        int   mrsp_rel, req_last, last_c;
        logic exp_req;
        acc      = (stall < TO);
        mrsp_rel = acc ? stall + 2 + delay : -1;
        req_last = acc ? stall + 1 : TO;
        last_c   = ((mrsp_rel > exp_lat) ? mrsp_rel : exp_lat) + 1;
        last_lsu = exp_lsu;
        exp_q.push_back({exp_lsu, exp_err, exp_rd, 8'(exp_lat)});
        for (int c = 0; c <= last_c; c++) begin
            bus.ifu_req_valid = ifu_v && (c <= exp_lat);
            bus.lsu_req_valid = lsu_v && (c <= exp_lat);
            bus.ifu_addr  = ia;
            bus.lsu_addr  = la;
            bus.lsu_wen   = wen;
            bus.lsu_wdata = wd;
            bus.lsu_wmask = wm;
            bus.mem_req_ready = acc && (c == stall + 1);
            if (c == mrsp_rel) begin
                bus.mem_resp_valid = 1'b1; bus.mem_rdata = mrd; bus.mem_resp_err = merr;
            end else if (stray && acc && c == stall + 1) begin
                bus.mem_resp_valid = 1'b1; bus.mem_rdata = ~mrd; bus.mem_resp_err = ~merr;
            end else begin
                bus.mem_resp_valid = 1'b0; bus.mem_rdata = $urandom;
                bus.mem_resp_err = 1'($urandom_range(0, 1));
            end
            #3;
            if (c == 0) begin
                check("ifu_ready_grant", 32'(bus.ifu_req_ready), 32'(ifu_v && !exp_lsu));
                check("lsu_ready_grant", 32'(bus.lsu_req_ready), 32'(exp_lsu));
            end else begin
                check("ready_low", 32'({bus.ifu_req_ready, bus.lsu_req_ready}), 32'(0));
            end
            exp_req = (c >= 1) && (c <= req_last);
            check("mem_req_valid", 32'(bus.mem_req_valid), 32'(exp_req));
            check("busy", 32'(busy), 32'((c >= 1) && (c <= exp_lat)));
            if (exp_req) begin
                check("mem_addr",  bus.mem_addr, exp_lsu ? la : ia);
                check("mem_wen",   32'(bus.mem_wen), 32'(exp_lsu && wen));
                check("mem_wmask", 32'(bus.mem_wmask), exp_lsu ? 32'(wm) : 32'(0));
                if (exp_lsu) check("mem_wdata", bus.mem_wdata, wd);
            end
            if (bus.ifu_resp_valid === 1'b1) observe(1'b0, bus.ifu_rdata, bus.ifu_resp_err, c);
            else check("ifu_err_idle", 32'(bus.ifu_resp_err), 32'(0));
            if (bus.lsu_resp_valid === 1'b1) observe(1'b1, bus.lsu_rdata, bus.lsu_resp_err, c);
            else check("lsu_err_idle", 32'(bus.lsu_resp_err), 32'(0));
            @(posedge clk); #1;
        end
        check("resp_missing", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic ifu_v, lsu_v; logic [31:0] ia, la; logic wen; logic [31:0] wd; logic [3:0] wm;
        int stall, delay; logic [31:0] mrd; logic merr; logic stray;
        logic exp_lsu; int exp_lat; logic exp_err; logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // lone fetch, fastest path
        vecs[0]  = '{1, 0, 32'h80000000, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h00000413, 0, 0, 0, 3, 0, 32'h00000413};
        // store with 3 stall cycles in REQ
        vecs[1]  = '{0, 1, 32'h0, 32'h80001000, 1, 32'hDEADBEEF, 4'hF, 3, 0, 32'h0, 0, 0, 1, 6, 0, 32'h0};
        // ties alternate IFU, LSU, IFU, LSU; stray resp on acceptance cycle
        vecs[2]  = '{1, 1, 32'h80000010, 32'h80002000, 0, 32'h0, 4'h0, 0, 0, 32'h11111111, 0, 1, 0, 3, 0, 32'h11111111};
        vecs[3]  = '{1, 1, 32'h80000014, 32'h80002004, 0, 32'h0, 4'h0, 0, 1, 32'h22222222, 0, 0, 1, 4, 0, 32'h22222222};
        vecs[4]  = '{1, 1, 32'h80000018, 32'h80002008, 1, 32'h12345678, 4'h3, 1, 0, 32'h33333333, 0, 0, 0, 4, 0, 32'h33333333};
        vecs[5]  = '{1, 1, 32'h8000001C, 32'h8000200C, 1, 32'hA5A5A5A5, 4'hC, 0, 2, 32'h44444444, 0, 0, 1, 5, 0, 32'h44444444};
        // memory never accepts: error at T+TO+1
        vecs[6]  = '{1, 0, 32'h80000020, 32'h0, 0, 32'h0, 4'h0, TO + 3, 0, 32'h55555555, 0, 0, 0, TO + 1, 1, 32'h0};
        // memory error on a load
        vecs[7]  = '{0, 1, 32'h0, 32'h80003000, 0, 32'h0, 4'h0, 1, 1, 32'hBAD0BAD0, 1, 0, 1, 5, 1, 32'hBAD0BAD0};
        // response on the last allowed cycle
        vecs[8]  = '{0, 1, 32'h0, 32'h80003004, 0, 32'h0, 4'h0, 2, 4, 32'h5A5A5A5A, 0, 0, 1, TO + 1, 0, 32'h5A5A5A5A};
        // response one cycle too late: timeout, late answer ignored
        vecs[9]  = '{1, 0, 32'h80000024, 32'h0, 0, 32'h0, 4'h0, 2, 5, 32'hFFFFFFFF, 0, 0, 0, TO + 1, 1, 32'h0};
        vecs[10] = '{0, 1, 32'h0, 32'h80003008, 0, 32'h0, 4'h0, TO - 2, 0, 32'h0F0F0F0F, 0, 0, 1, TO + 1, 0, 32'h0F0F0F0F};

        // ---- reset ----
        rst = 1'b1;
        bus.ifu_req_valid = 0; bus.ifu_addr = 0;
        bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_wen = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = 0; bus.mem_resp_err = 0;
        last_lsu = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #3;
        check("rst_state", 32'(state_dbg), 32'(DBG_IDLE));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'(0));
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_fields", 32'({bus.mem_wen, bus.mem_wmask}), 32'(0));
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_resp", 32'({bus.ifu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_valid, bus.lsu_resp_err}), 32'(0));
        check("rst_rdata", bus.ifu_rdata | bus.lsu_rdata, 32'h0);
        check("rst_ready", 32'({bus.ifu_req_ready, bus.lsu_req_ready}), 32'(0));
        @(posedge clk); #1;

        // ---- table ----
        for (int i = 0; i < 11; i++) begin
            do_txn(vecs[i].ifu_v, vecs[i].lsu_v, vecs[i].ia, vecs[i].la, vecs[i].wen, vecs[i].wd, vecs[i].wm,
                   vecs[i].stall, vecs[i].delay, vecs[i].mrd, vecs[i].merr, vecs[i].stray,
                   vecs[i].exp_lsu, vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_rd);
        end

        // ---- random ----
        for (int n = 0; n < 40; n++) begin
            logic iv, lv, merr, stray, own;
            logic [31:0] ia, la, wd, mrd, rd;
            logic [3:0] wm;
            logic wen, err;
            int sel, st, dl, lat;
            sel   = $urandom_range(0, 2);
            iv    = (sel != 1);
            lv    = (sel != 0);
            st    = ($urandom_range(0, 3) == 0) ? TO + 3 : $urandom_range(0, TO - 2);
            dl    = $urandom_range(0, 6);
            ia    = $urandom; la = $urandom; wd = $urandom; mrd = $urandom;
            wm    = 4'($urandom_range(0, 15));
            wen   = 1'($urandom_range(0, 1));
            merr  = ($urandom_range(0, 3) == 0);
            stray = 1'($urandom_range(0, 1));
            predict(iv, lv, st, dl, mrd, merr, own, lat, err, rd);
            do_txn(iv, lv, ia, la, wen, wd, wm, st, dl, mrd, merr, stray, own, lat, err, rd);
        end

        // ---- reset while waiting for memory ----
        bus.lsu_req_valid = 1; bus.lsu_addr = 32'h80004000; bus.lsu_wen = 0; bus.ifu_req_valid = 0;
        #3 check("rw_lsu_ready", 32'(bus.lsu_req_ready), 32'(1));
        @(posedge clk); #1;
        bus.lsu_req_valid = 0; bus.mem_req_ready = 1;
        #3 check("rw_req", 32'(bus.mem_req_valid), 32'(1));
        @(posedge clk); #1;
        bus.mem_req_ready = 0; rst = 1;
        bus.mem_resp_valid = 1; bus.mem_rdata = 32'hCAFEF00D; bus.mem_resp_err = 1;
        #3;
        check("rw_in_wait", 32'(state_dbg), 32'(DBG_WAIT));
        check("rw_busy_wait", 32'(busy), 32'(1));
        @(posedge clk); #1;
        rst = 0; bus.mem_rdata = 32'h12345678;   // late answer, must be ignored
        #3;
        check("rw_state", 32'(state_dbg), 32'(DBG_IDLE));
        check("rw_busy", 32'(busy), 32'(0));
        check("rw_mem_req_valid", 32'(bus.mem_req_valid), 32'(0));
        check("rw_mem_addr", bus.mem_addr, 32'h0);
        check("rw_resp", 32'({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.lsu_resp_err}), 32'(0));
        check("rw_rdata", bus.lsu_rdata, 32'h0);
        @(posedge clk); #1;
        bus.mem_resp_valid = 0; bus.mem_resp_err = 0;
        #3;
        check("rw_late_busy", 32'(busy), 32'(0));
        check("rw_late_resp", 32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'(0));
        @(posedge clk); #1;
        // first tie after reset goes to IFU
        do_txn(1, 1, 32'h80000100, 32'h80005000, 0, 32'h0, 4'h0, 0, 0, 32'h0000ABCD, 0, 0,
               0, 3, 0, 32'h0000ABCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
